// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed seven-segment credit/price display.
package display_pkg;

   localparam int BCD_W   = 4;
   localparam int DIGIT_W = 8;

   typedef enum logic {IDLE, CONVERT} state_e;

   // Largest value representable in n decimal digits; the saturation ceiling.
   function automatic int unsigned pow10m1(input int unsigned n);
      int unsigned r;
      r = 1;
      for (int unsigned i = 0; i < n; i++) r = r * 10;
      return r - 1;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3-then-shift step per cycle, VALUE_W steps.
// done_o is asserted during the final step; bcd_o then carries that step's result.
module bin2bcd_seq
   import display_pkg::*;
#(
   parameter int VALUE_W    = 14,
   parameter int NUM_DIGITS = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start_i,
   input  logic [VALUE_W-1:0]            value_i,
   output logic                          done_o,
   output logic [NUM_DIGITS*BCD_W-1:0]   bcd_o
);

   localparam int BCD_TOT = NUM_DIGITS * BCD_W;
   localparam int CNT_W   = $clog2(VALUE_W + 1);

   logic                active_q, active_d;
   logic [VALUE_W-1:0]  bin_q, bin_d;
   logic [BCD_TOT-1:0]  bcd_q, bcd_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [BCD_TOT-1:0]  adj;

   always_comb begin
      adj = bcd_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd_q[i*BCD_W +: BCD_W] >= BCD_W'(5))
            adj[i*BCD_W +: BCD_W] = bcd_q[i*BCD_W +: BCD_W] + BCD_W'(3);
      end
   end

   always_comb begin
      // NOTE: every _d is given its hold value first, so no path through this block leaves one unassigned and no latch is inferred.
      active_d = active_q;
      bin_d    = bin_q;
      bcd_d    = bcd_q;
      cnt_d    = cnt_q;
      done_o   = 1'b0;
      if (start_i) begin
         active_d = 1'b1;
         bin_d    = value_i;
         bcd_d    = '0;
         cnt_d    = '0;
      end else if (active_q) begin
         {bcd_d, bin_d} = {adj, bin_q} << 1;
         cnt_d          = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_W'(VALUE_W - 1)) begin
            done_o   = 1'b1;
            active_d = 1'b0;
         end
      end
   end

   assign bcd_o = bcd_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q <= 1'b0;
         bin_q    <= '0;
         bcd_q    <= '0;
         cnt_q    <= '0;
      end else begin
         // NOTE: non-blocking assignment so every flop samples pre-edge values regardless of statement order.
         active_q <= active_d;
         bin_q    <= bin_d;
         bcd_q    <= bcd_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// Converts a binary amount to BCD and round-robins it onto a shared 7-seg decoder with active-low anodes.
// Optional: define BLANK_LEADING_ZERO_EN to keep anodes dark above the most-significant nonzero digit.
module display_scan_ctrl
   import display_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int VALUE_W    = 14,
   parameter int SCAN_DIV   = 50000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [VALUE_W-1:0]      value_in,
   input  logic                    load,
   output logic                    busy,
   output logic                    overflow,
   output logic [DIGIT_W-1:0]      digit,
   output logic [NUM_DIGITS-1:0]   an_n
);

   localparam int          BCD_TOT = NUM_DIGITS * BCD_W;
   localparam int          IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int          PRE_W   = $clog2(SCAN_DIV);
   localparam int unsigned SAT_MAX = pow10m1(NUM_DIGITS);

   state_e                 state_q, state_d;
   logic                   ovf_q, ovf_d;
   logic [BCD_TOT-1:0]     disp_q, disp_d;
   logic [PRE_W-1:0]       pre_q;
   logic [IDX_W-1:0]       idx_q, idx_p_q;
   logic                   an_vld_q;
   logic [DIGIT_W-1:0]     digit_q;
   logic [NUM_DIGITS-1:0]  an_q, an_next;
   logic                   sat, accept, conv_done;
   logic [VALUE_W-1:0]     operand;
   logic [BCD_TOT-1:0]     conv_bcd;

   assign sat     = 32'(value_in) > SAT_MAX;
   assign operand = sat ? VALUE_W'(SAT_MAX) : value_in;
   assign accept  = (state_q == IDLE) && load;

   bin2bcd_seq #(
      .VALUE_W    (VALUE_W),
      .NUM_DIGITS (NUM_DIGITS)
   ) u_bin2bcd (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (accept),
      .value_i (operand),
      .done_o  (conv_done),
      .bcd_o   (conv_bcd)
   );

   always_comb begin
      state_d = state_q;
      ovf_d   = ovf_q;
      disp_d  = disp_q;
      case (state_q)
         IDLE: begin
            if (load) begin
               state_d = CONVERT;
               ovf_d   = sat;
            end
         end
         CONVERT: begin
            if (conv_done) begin
               state_d = IDLE;
               disp_d  = conv_bcd;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Anode uses the idx that produced the digit one stage earlier, matching the decoder's register.
   always_comb begin
      an_next = ~(NUM_DIGITS'(1) << idx_p_q);
`ifdef BLANK_LEADING_ZERO_EN
      begin
         logic [IDX_W-1:0] msd;
         msd = '0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (disp_q[i*BCD_W +: BCD_W] != '0) msd = IDX_W'(i);
         end
         if (idx_p_q > msd) an_next = '1;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         ovf_q    <= 1'b0;
         disp_q   <= '0;
         pre_q    <= '0;
         idx_q    <= '0;
         idx_p_q  <= '0;
         an_vld_q <= 1'b0;
         digit_q  <= '0;
         an_q     <= '1;
      end else begin
         state_q <= state_d;
         ovf_q   <= ovf_d;
         disp_q  <= disp_d;
         if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
            pre_q <= '0;
            idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
         end else begin
            pre_q <= pre_q + PRE_W'(1);
         end
         digit_q  <= {{(DIGIT_W - BCD_W){1'b0}}, disp_q[idx_q*BCD_W +: BCD_W]};
         idx_p_q  <= idx_q;
         an_vld_q <= 1'b1;
         an_q     <= an_vld_q ? an_next : '1;
      end
   end

   assign busy     = (state_q == CONVERT);
   assign overflow = ovf_q;
   assign digit    = digit_q;
   assign an_n     = an_q;

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Sequencer that time-shares the single seven-segment decoder across NUM_DIGITS multiplexed digits of the vending-machine credit/price display. Accepts a binary amount, converts it to BCD with a sequential shift-add-3 (double-dabble) engine, and then round-robins the decoder input and the active-low anode enables at a fixed refresh rate. The display stays tear-free: a new value appears only after its conversion completes.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (index 0 = least significant).
VALUE_W, 14, width of the binary input amount.
SCAN_DIV, 50000, clk cycles each digit stays active (minimum 2).

Ports:
clk  input  1  system clock; all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
value_in  input  VALUE_W  binary amount to display.
load  input  1  single-cycle request to convert and display value_in.
busy  output  1  conversion in progress; load ignored while high.
overflow  output  1  latched: last accepted value exceeded 10^NUM_DIGITS-1.
digit  output  8  BCD code for the shared decoder (upper 4 bits always 0).
an_n  output  NUM_DIGITS  active-low anode enables, one-hot-low when lit.

Behaviour:
- Reset (async, rst_n=0): FSM IDLE, busy=0, overflow=0, displayed BCD register all 0, scan index 0, prescaler 0, digit=0, an_n all ones. After release, an_n goes active two cycles later (pipeline fill).
- FSM states: IDLE, CONVERT.
- IDLE: load=1 accepts value_in. If value_in > 10^NUM_DIGITS-1, the operand saturates to 10^NUM_DIGITS-1 and overflow=1; otherwise overflow=0. Next state is CONVERT and busy=1 from the next cycle.
- CONVERT: exactly VALUE_W cycles, one add-3-then-shift step per cycle. The result is written to the displayed BCD register on the last step's clock edge. busy falls on that same edge, so it is high for exactly VALUE_W cycles. Return to IDLE.
- load while busy: ignored, with no queueing. load arriving on the cycle busy falls: not accepted, because the FSM is not yet in IDLE.
- During CONVERT, scanning continues from the old displayed BCD register.
- Scan prescaler counts 0..SCAN_DIV-1 and wraps. At terminal count, the scan index increments mod NUM_DIGITS (NUM_DIGITS-1 wraps to 0).
- digit is registered: {4'b0, bcd[idx]}, updated one cycle after idx changes.
- The downstream decoder adds one registered stage. an_n is therefore a two-stage delayed copy of idx (~(1<<idx)), so the anode switches on the same edge the segment pins change. No ghosting.
- Reset mid-conversion aborts the conversion. The display returns to all zeros and overflow clears.
- Conversion result is an arithmetic identity: the displayed BCD decimal value equals min(value_in, 10^NUM_DIGITS-1).

Optional Feature:
BLANK_LEADING_ZERO_EN
- Defined: digits above the most-significant nonzero digit have their an_n bit forced to 1. Digit 0 is always lit, so the value 0 shows a single "0". The blanking decision uses the same delayed idx as an_n.
- Undefined: all NUM_DIGITS digits are lit, including leading zeros.

Decomposition:
- Package display_pkg: BCD_W=4, DIGIT_W=8, the FSM state enum {IDLE, CONVERT}, and a function returning 10^n-1 for saturation.
- One sub-module, bin2bcd_seq: the double-dabble engine with start/done, VALUE_W and NUM_DIGITS parameters.
- display_scan_ctrl holds the FSM wrapper, displayed BCD register, prescaler, index, and the an_n delay pipeline.
- The decoder is instantiated alongside by the integrator, not inside this block.

Test Plan:
- Reset: assert rst_n=0 mid-scan -> an_n=4'b1111, digit=0, busy=0, overflow=0 immediately. Release -> an_n=4'b1110 two cycles later.
- Load 1234 (SCAN_DIV=4) -> busy high exactly 14 cycles. digit then cycles 4,3,2,1 every 4 cycles; an_n 1110,1101,1011,0111 lags digit by exactly 1 cycle.
- Load 12000 -> overflow=1, digits 9,9,9,9. Subsequent load 5 -> overflow=0, digits 5,0,0,0.
- Load 42, then load 77 three cycles later while busy -> 77 ignored. Display shows 42; busy pulse width is 14.
- Scan wrap: observe 3 full rotations -> idx 3 wraps to 0. No cycle has more than one an_n bit low.
- BLANK_LEADING_ZERO_EN, load 7 -> only an_n[0] ever low. Load 0 -> only digit 0 lit showing 0. Load 1005 -> all four lit (internal zeros shown).
